// File: rtl/toy_mem_arbiter_if.sv
// Bus bundle for toy_mem_arbiter: fetch port, data port, shared memory port
// and arbiter debug state. slave = arbiter view, master = core/memory view.
interface toy_mem_arbiter_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  // Request ports: a requester raises REQ with its address (and RW/WDATA) and
  // holds them stable until GNT; the access transfers in the cycle REQ&GNT.
  // RVALID/RDATA answer a read exactly one cycle later with no backpressure.
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          I_GNT;
  logic          I_RVALID;
  logic [DW-1:0] I_RDATA;

  logic          D_REQ;
  logic          D_RW;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [DW-1:0] D_RDATA;

  logic          M_REQ;
  logic          M_RW;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WDATA;
  logic [DW-1:0] M_RDATA;

  logic [1:0]    DBG_RSP_STATE;
  logic [3:0]    DBG_STREAK;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, M_RDATA,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    output M_REQ, M_RW, M_ADDR, M_WDATA, DBG_RSP_STATE, DBG_STREAK
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, M_RDATA,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    input  M_REQ, M_RW, M_ADDR, M_WDATA, DBG_RSP_STATE, DBG_STREAK
  );
endinterface

// File: rtl/toy_mem_arbiter.sv
// Fetch/data arbiter for one single-ported synchronous memory, data-priority
// with a bounded data streak. Optional ARB_CONFLICT_CNT_EN adds CONFLICT_CNT.
module toy_mem_arbiter #(
  parameter int AW          = 30,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic CLK,
  input  logic RST,
`ifdef ARB_CONFLICT_CNT_EN
  output logic [31:0] CONFLICT_CNT,
`endif
  toy_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_DRD  = 2'd2,
    RSP_DWR  = 2'd3
  } rsp_state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_DSTREAK);

  rsp_state_t r_state;
  rsp_state_t w_next_state;
  logic [3:0] r_streak;
  logic       w_i_gnt;
  logic       w_d_gnt;

  // Grants are forced low while reset is held so nothing reaches the memory.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!RST) begin
      if (bus.D_REQ && (!bus.I_REQ || (r_streak < LP_MAX))) begin
        w_d_gnt = 1'b1;
      end else if (bus.I_REQ) begin
        w_i_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    bus.I_GNT   = w_i_gnt;
    bus.D_GNT   = w_d_gnt;
    bus.M_REQ   = w_i_gnt | w_d_gnt;
    bus.M_RW    = 1'b0;
    bus.M_ADDR  = '0;
    bus.M_WDATA = '0;
    if (w_d_gnt) begin
      bus.M_RW    = bus.D_RW;
      bus.M_ADDR  = bus.D_ADDR;
      bus.M_WDATA = bus.D_WDATA;
    end else if (w_i_gnt) begin
      bus.M_ADDR  = bus.I_ADDR;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_streak <= 4'd0;
    end else if (w_i_gnt || !bus.I_REQ) begin
      r_streak <= 4'd0;
    end else if (w_d_gnt && (r_streak < LP_MAX)) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  // The response state simply records what was issued last cycle, so a new
  // grant can overlap the response of the previous one.
  always_comb begin
    w_next_state = RSP_NONE;
    if (w_i_gnt) begin
      w_next_state = RSP_I;
    end else if (w_d_gnt) begin
      w_next_state = bus.D_RW ? RSP_DWR : RSP_DRD;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= RSP_NONE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    bus.I_RVALID = (r_state == RSP_I);
    bus.D_RVALID = (r_state == RSP_DRD);
    bus.I_RDATA  = bus.I_RVALID ? bus.M_RDATA : '0;
    bus.D_RDATA  = bus.D_RVALID ? bus.M_RDATA : '0;
  end

  assign bus.DBG_RSP_STATE = r_state;
  assign bus.DBG_STREAK    = r_streak;

`ifdef ARB_CONFLICT_CNT_EN
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_conflict_cnt <= 32'd0;
    end else if (bus.I_REQ && bus.D_REQ && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign CONFLICT_CNT = r_conflict_cnt;
`endif

endmodule
